// File: rtl/stopwatch_control.sv
// Stopwatch controller: run/pause/lap FSM driving a BCD 00.00-59.99 count
// with a registered display that shows either the live count or a lap snapshot.
`default_nettype none

module stopwatch_control #(
    parameter logic WRAP_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    input  logic       tick,
    output logic       device_running,
    output logic [3:0] hund_ones,
    output logic [3:0] hund_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic       lap_active,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        LAP     = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    // Count words are packed {sec_tens, sec_ones, hund_tens, hund_ones}.
    localparam logic [15:0] MAX_COUNT = 16'h5999;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] disp_q, disp_d;
    logic        ovf_q, ovf_d;
    logic        counting;
    logic        locked;
    logic        at_max;
    logic [15:0] count_inc;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (v[11:8] != 4'd9) begin
                    r[11:8] = v[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    r[15:12] = (v[15:12] == 4'd5) ? 4'd0 : v[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign counting  = tick && ((state_q == RUNNING) || (state_q == LAP));
    assign at_max    = (count_q == MAX_COUNT);
    assign count_inc = bcd_inc(count_q);
    // Only saturation can set overflow when wrapping is disabled, so it doubles as the lock.
    assign locked    = !WRAP_EN && ovf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = IDLE;
            count_d = 16'h0000;
            snap_d  = 16'h0000;
            ovf_d   = 1'b0;
        end else begin
            if (counting) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    if (WRAP_EN) begin
                        count_d = 16'h0000;
                    end
                end else begin
                    count_d = count_inc;
                end
            end

            case (state_q)
                IDLE: begin
                    if (start_stop && !locked) state_d = RUNNING;
                end
                RUNNING: begin
                    if (start_stop) begin
                        state_d = PAUSED;
                    end else if (lap) begin
                        state_d = LAP;
                        snap_d  = count_q;
                    end
                end
                LAP: begin
                    if (start_stop)  state_d = PAUSED;
                    else if (lap)    state_d = RUNNING;
                end
                PAUSED: begin
                    if (start_stop && !locked) state_d = RUNNING;
                end
                default: state_d = IDLE;
            endcase

            if (counting && at_max && !WRAP_EN) begin
                state_d = PAUSED;
            end
        end
    end

    assign disp_d = (state_q == LAP) ? snap_q : count_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            count_q <= 16'h0000;
            snap_q  <= 16'h0000;
            disp_q  <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign device_running = (state_q == RUNNING) || (state_q == LAP);
    assign lap_active     = (state_q == LAP);
    assign overflow       = ovf_q;
    assign hund_ones      = disp_q[3:0];
    assign hund_tens      = disp_q[7:4];
    assign sec_ones       = disp_q[11:8];
    assign sec_tens       = disp_q[15:12];

endmodule

`default_nettype wire

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 Parameter: WRAP_EN, default 1; 1 = count wraps 59.99 -> 00.00, 0 = count saturates at 59.99.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  reset; asynchronous, active-low.
REQ-004 start_stop  input  1  single-cycle pulse, already debounced; toggles run/pause.
REQ-005 lap  input  1  single-cycle pulse; freezes or releases the display.
REQ-006 clear  input  1  single-cycle pulse; zeroes the stopwatch.
REQ-007 tick  input  1  hundredth-of-second pulse from the tick counter; one cycle wide.
REQ-008 device_running  output  1  enable to the tick counter.
REQ-009 hund_ones, hund_tens  output  4 each  displayed hundredths, BCD 0-9.
REQ-010 sec_ones, sec_tens  output  4 each  displayed seconds, BCD ones 0-9, tens 0-5.
REQ-011 lap_active  output  1  high while the display shows the frozen lap value.
REQ-012 overflow  output  1  sticky flag set on the 59.99 -> next tick event.

Function
REQ-013 FSM states SHALL be IDLE, RUNNING, LAP and PAUSED, held in a registered state variable.
REQ-014 IDLE: start_stop -> RUNNING; lap is ignored.
REQ-015 RUNNING: start_stop -> PAUSED; lap -> LAP, and the live count is latched into the lap snapshot on the same edge.
REQ-016 LAP: lap -> RUNNING; start_stop -> PAUSED, and the display returns to the live count.
REQ-017 PAUSED: start_stop -> RUNNING; lap is ignored.
REQ-018 Input priority SHALL be clear > start_stop > lap when pulses coincide.
REQ-019 clear in any state -> IDLE on the next edge, with live count = 0, snapshot = 0 and overflow = 0.
REQ-020 device_running SHALL be decoded from the state register: 1 in RUNNING and LAP, 0 otherwise.
REQ-021 The live count SHALL advance by 0.01 s only on a cycle with tick=1 while the current state is RUNNING or LAP; ticks in IDLE or PAUSED are dropped.
REQ-022 Counting SHALL be a BCD cascade:
- hund_ones 9 -> 0 carries into hund_tens.
- hund_tens 9 -> 0 carries into sec_ones.
- sec_ones 9 -> 0 carries into sec_tens.
- sec_tens 5 -> 0 is the full wrap.
REQ-023 tick at 59.99 with WRAP_EN=1: count -> 00.00, overflow <= 1, state unchanged.
REQ-024 tick at 59.99 with WRAP_EN=0: count holds 59.99, overflow <= 1, state -> PAUSED.
- After this event, start_stop is ignored until clear.
REQ-025 tick coinciding with start_stop in RUNNING: the tick SHALL be counted and the state moves to PAUSED.
REQ-026 tick coinciding with clear: clear wins and the count is 0.
REQ-027 tick coinciding with lap in RUNNING: the snapshot SHALL capture the pre-increment value, and the live count still increments.
REQ-028 Display digit outputs SHALL be registered.
- Source: the snapshot when the state is LAP, otherwise the live count.
- Latency: the outputs reflect a count or state change one cycle after it.
REQ-029 lap_active SHALL equal (state == LAP).
REQ-030 overflow SHALL stay set until clear or reset.

Reset
REQ-031 On RESET low, asynchronously:
- state = IDLE.
- live count, snapshot and all digit outputs = 0.
- device_running = 0, lap_active = 0, overflow = 0.
REQ-032 On RESET release, the first active edge SHALL evaluate inputs normally; pulses coinciding with RESET low are lost.
REQ-033 RESET asserted mid-count SHALL abandon the count with no residual carry or snapshot.

Verification
REQ-034 Start/pause/resume: start_stop, 150 ticks, start_stop, 20 ticks, start_stop, 5 ticks -> display 01.55, device_running 1-0-1.
REQ-035 Lap: run to 02.37, lap, 100 more ticks -> display 02.37 with lap_active=1; then lap -> display 03.37 with lap_active=0.
REQ-036 Wrap, WRAP_EN=1: run to 59.99, one tick -> 00.00, overflow=1, state RUNNING.
REQ-037 Saturate, WRAP_EN=0: run to 59.99, one tick -> 59.99, overflow=1, device_running=0; start_stop ignored; clear -> 00.00, overflow=0, IDLE.
REQ-038 Coincidence:
- clear+start_stop+tick in RUNNING at 10.00 -> IDLE, 00.00.
- start_stop+tick at 10.00 -> PAUSED, 10.01.
REQ-039 Async reset: assert RESET in LAP at 05.42 between clock edges -> all outputs 0 immediately, IDLE after release.
